// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and helpers for the HUB75 BCM scanner.
//   scan_state_t   : scan FSM state encoding
//   red/green/blue_idx : bit position of a channel's bit-plane inside a
//                        packed {R,G,B} pixel of bpc bits per channel
//   bcm_on_cycles  : lit time of a bit-plane (binary weighted)
package hub75_pkg;

  typedef logic [2:0] scan_state_t;

  localparam scan_state_t S_IDLE     = 3'd0;
  localparam scan_state_t S_PREFETCH = 3'd1;
  localparam scan_state_t S_SHIFT    = 3'd2;
  localparam scan_state_t S_LATCH    = 3'd3;
  localparam scan_state_t S_UNLATCH  = 3'd4;
  localparam scan_state_t S_DISPLAY  = 3'd5;

  function automatic int red_idx(input int bpc, input int p);
    return 2 * bpc + p;
  endfunction

  function automatic int green_idx(input int bpc, input int p);
    return bpc + p;
  endfunction

  function automatic int blue_idx(input int bpc, input int p);
    return p;
  endfunction

  function automatic int bcm_on_cycles(input int on_base, input int p);
    return on_base << p;
  endfunction

endpackage

// File: rtl/hub75_bcm_scanner_if.sv
// hub75_bcm_scanner_if: framebuffer read port.
//   rd_en            : read strobe (scanner -> RAM)
//   rd_row / rd_col  : scan-row / column address; bottom bank is row+ROWS/2
//   top_pix/bot_pix  : {R,G,B} pixels, valid the clk after rd_en and held
//                      by the RAM until the next read
// master = scanner, slave = framebuffer.
interface hub75_bcm_scanner_if #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int BPC  = 4
);
  localparam int RW = $clog2(ROWS / 2);
  localparam int CW = $clog2(COLS);

  logic              rd_en;
  logic [RW-1:0]     rd_row;
  logic [CW-1:0]     rd_col;
  logic [3*BPC-1:0]  top_pix;
  logic [3*BPC-1:0]  bot_pix;

  modport master (output rd_en, rd_row, rd_col, input top_pix, bot_pix);
  modport slave  (input rd_en, rd_row, rd_col, output top_pix, bot_pix);
endinterface

// File: rtl/bcm_timer.sv
// bcm_timer: loadable down-counter for the DISPLAY phase.
//   clk, reset (async, active low)
//   load     : load load_val on this clk
//   load_val : value loaded (lit cycles - 1)
//   done     : counter has reached zero
module bcm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 panel scan driver with binary-code modulation.
// Per scan row and bit-plane: prefetch column 0, shift COLS columns (two
// clks each: data/sclk low, then sclk high), latch, unlatch, then light the
// plane for ON_BASE<<plane clks.
//   clk, reset (async, active low), enable (start / keep framing)
//   fb          : framebuffer read port (master side)
//   sclk, R0..B1: panel shift clock and colour data
//   A, lch      : row select, latch
//   blank       : 1 = panel dark
//   frame_done  : one-clk pulse after the last plane of the last row
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int ROWS    = 32,
  parameter int BPC     = 4,
  parameter int ON_BASE = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  hub75_bcm_scanner_if.master       fb,
  output logic                      sclk,
  output logic                      R0,
  output logic                      G0,
  output logic                      B0,
  output logic                      R1,
  output logic                      G1,
  output logic                      B1,
  output logic [$clog2(ROWS/2)-1:0] A,
  output logic                      lch,
  output logic                      blank,
  output logic                      frame_done
);
  localparam int SR  = ROWS / 2;
  localparam int RW  = $clog2(SR);
  localparam int CW  = $clog2(COLS);
  localparam int SW  = CW + 1;
  localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int TW  = $clog2(ON_BASE << (BPC - 1)) + 1;
  localparam int PXW = 3 * BPC;

  scan_state_t   state;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;
  logic [SW-1:0] sh_cnt;       // {column, phase}
  logic [RW-1:0] last_row;
  logic [CW-1:0] last_col;
  logic [2:0]    hold_top, hold_bot;
  logic [2:0]    top_bits, bot_bits;

  logic [CW-1:0] col, cur_col;
  logic          phase, shift_last, col_last, in_shift, rd_req;
  logic          tmr_load, disp_done;
  logic [TW-1:0] tmr_val;

  assign col        = sh_cnt[SW-1:1];
  assign phase      = sh_cnt[0];
  assign shift_last = (sh_cnt == SW'(2 * COLS - 1));
  assign col_last   = (col == CW'(COLS - 1));
  assign in_shift   = (state == S_SHIFT);

  assign tmr_load = (state == S_UNLATCH);
  assign tmr_val  = TW'(bcm_on_cycles(ON_BASE, int'(plane)) - 1);

  bcm_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (disp_done)
  );

  // Read column c+1 during phase 0 of column c; the RAM holds its output
  // through phase 1, so phase 0 of every column sees its own pixel live.
  assign rd_req  = (state == S_PREFETCH) || (in_shift && !phase && !col_last);
  assign cur_col = (state == S_PREFETCH) ? '0 : col + 1'b1;

  assign fb.rd_en  = rd_req;
  assign fb.rd_col = rd_req ? cur_col : last_col;
  assign fb.rd_row = rd_req ? row : last_row;

  always_comb begin
    top_bits[2] = |(fb.top_pix & (PXW'(1) << red_idx(BPC, int'(plane))));
    top_bits[1] = |(fb.top_pix & (PXW'(1) << green_idx(BPC, int'(plane))));
    top_bits[0] = |(fb.top_pix & (PXW'(1) << blue_idx(BPC, int'(plane))));
    bot_bits[2] = |(fb.bot_pix & (PXW'(1) << red_idx(BPC, int'(plane))));
    bot_bits[1] = |(fb.bot_pix & (PXW'(1) << green_idx(BPC, int'(plane))));
    bot_bits[0] = |(fb.bot_pix & (PXW'(1) << blue_idx(BPC, int'(plane))));
  end

  // Phase 1 replays the bits captured in phase 0, since the RAM output has
  // already moved on to the next column.
  always_comb begin
    {R0, G0, B0} = 3'b000;
    {R1, G1, B1} = 3'b000;
    if (in_shift) begin
      {R0, G0, B0} = phase ? hold_top : top_bits;
      {R1, G1, B1} = phase ? hold_bot : bot_bits;
    end
  end

  assign sclk  = in_shift && phase;
  assign lch   = (state == S_LATCH);
  assign blank = (state != S_DISPLAY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_row <= '0;
      last_col <= '0;
      hold_top <= '0;
      hold_bot <= '0;
    end else begin
      if (rd_req) begin
        last_row <= row;
        last_col <= cur_col;
      end
      if (in_shift && !phase) begin
        hold_top <= top_bits;
        hold_bot <= bot_bits;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      row        <= '0;
      plane      <= '0;
      sh_cnt     <= '0;
      A          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          state <= S_PREFETCH;
          row   <= '0;
          plane <= '0;
        end
        S_PREFETCH: begin
          state  <= S_SHIFT;
          sh_cnt <= '0;
        end
        S_SHIFT: begin
          if (shift_last) begin
            state <= S_LATCH;
            A     <= row;        // row select moves with the latch pulse
          end else begin
            sh_cnt <= sh_cnt + 1'b1;
          end
        end
        S_LATCH:   state <= S_UNLATCH;
        S_UNLATCH: state <= S_DISPLAY;
        S_DISPLAY: if (disp_done) begin
          if (plane != PW'(BPC - 1)) begin
            plane <= plane + 1'b1;
            state <= S_PREFETCH;
          end else begin
            plane <= '0;
            if (row != RW'(SR - 1)) begin
              row   <= row + 1'b1;
              state <= S_PREFETCH;
            end else begin
              row        <= '0;
              frame_done <= 1'b1;
              state      <= enable ? S_PREFETCH : S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
